// File: rtl/elevator_scheduler.sv
// Three-floor elevator car controller: directional sweep over the latched hall/car
// requests, door timing, and one-cycle clear pulses back to the request latches.
module elevator_scheduler #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic floor1up,
  input  logic floor2down,
  input  logic floor2up,
  input  logic floor3down,
  input  logic floor1button,
  input  logic floor2button,
  input  logic floor3button,
  output logic floor_1_indi,
  output logic floor_2_indi,
  output logic floor_3_indi,
  output logic door_open,
  output logic floor1up_clear,
  output logic floor2down_clear,
  output logic floor2up_clear,
  output logic floor3down_clear,
  output logic floor1_button_clear,
  output logic floor2_button_clear,
  output logic floor3_button_clear
);

  localparam int unsigned MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);
  localparam int unsigned NREQ       = 7;

  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DOOR      = 2'd1;
  localparam logic [1:0] S_MOVE_UP   = 2'd2;
  localparam logic [1:0] S_MOVE_DOWN = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [1:0] FLOOR_1 = 2'd1;
  localparam logic [1:0] FLOOR_2 = 2'd2;
  localparam logic [1:0] FLOOR_3 = 2'd3;

  // Request vector bit positions
  localparam int unsigned R_F1UP = 0;
  localparam int unsigned R_F2DN = 1;
  localparam int unsigned R_F2UP = 2;
  localparam int unsigned R_F3DN = 3;
  localparam int unsigned R_B1   = 4;
  localparam int unsigned R_B2   = 5;
  localparam int unsigned R_B3   = 6;

  localparam logic [NREQ-1:0] FLOOR1_MASK = 7'b0010001;
  localparam logic [NREQ-1:0] FLOOR2_MASK = 7'b0100110;
  localparam logic [NREQ-1:0] FLOOR3_MASK = 7'b1001000;

  logic [1:0]      state_q, state_d;
  logic [1:0]      floor_q, floor_d;
  logic            dir_q, dir_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      indi_q, indi_d;
  logic            door_q, door_d;
  logic [NREQ-1:0] clr_q, clr_d;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] eff;
  logic [2:0]      pend;
  logic            ahead_cur;
  logic            behind_cur;
  logic [NREQ-1:0] here_all;
  logic [NREQ-1:0] svc_here;
  logic            mv_up;
  logic [1:0]      nfloor;
  logic            nahead;
  logic [NREQ-1:0] svc_new;

  function automatic logic [2:0] floor_pending(input logic [NREQ-1:0] r);
    floor_pending = {r[R_F3DN] | r[R_B3],
                     r[R_F2DN] | r[R_F2UP] | r[R_B2],
                     r[R_F1UP] | r[R_B1]};
  endfunction

  function automatic logic [NREQ-1:0] floor_mask(input logic [1:0] f);
    logic [NREQ-1:0] m;
    case (f)
      FLOOR_1: m = FLOOR1_MASK;
      FLOOR_2: m = FLOOR2_MASK;
      FLOOR_3: m = FLOOR3_MASK;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Anything pending strictly beyond floor f in direction d
  function automatic logic ahead_of(input logic [2:0] p, input logic [1:0] f, input logic d);
    logic a;
    a = 1'b0;
    if (d == DIR_UP) begin
      case (f)
        FLOOR_1: a = p[1] | p[2];
        FLOOR_2: a = p[2];
        default: a = 1'b0;
      endcase
    end else begin
      case (f)
        FLOOR_3: a = p[1] | p[0];
        FLOOR_2: a = p[0];
        default: a = 1'b0;
      endcase
    end
    return a;
  endfunction

  // Requests at floor f that may be answered while travelling in d
  function automatic logic [NREQ-1:0] service_set(input logic [NREQ-1:0] r, input logic [1:0] f,
                                                  input logic d, input logic none_ahead);
    logic [NREQ-1:0] m;
    m = r & floor_mask(f);
    if (f == FLOOR_2 && !none_ahead) begin
      if (d == DIR_UP)   m[R_F2DN] = 1'b0;
      if (d == DIR_DOWN) m[R_F2UP] = 1'b0;
    end
    return m;
  endfunction

  assign req = {floor3button, floor2button, floor1button,
                floor3down, floor2up, floor2down, floor1up};

  // A clear being driven this cycle hides the latch that has not released yet
  assign eff        = req & ~clr_q;
  assign pend       = floor_pending(eff);
  assign ahead_cur  = ahead_of(pend, floor_q, dir_q);
  assign behind_cur = ahead_of(pend, floor_q, ~dir_q);
  assign here_all   = eff & floor_mask(floor_q);
  assign svc_here   = service_set(eff, floor_q, dir_q, ~ahead_cur);

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    clr_d   = '0;
    door_d  = 1'b0;
    indi_d  = indi_q;
    mv_up   = (state_q == S_MOVE_UP);
    nfloor  = mv_up ? floor_q + 2'd1 : floor_q - 2'd1;
    nahead  = ahead_of(pend, nfloor, dir_q);
    svc_new = service_set(eff, nfloor, dir_q, ~nahead);

    case (state_q)
      S_IDLE, S_DOOR: begin
        if (state_q == S_IDLE && here_all != '0) begin
          state_d = S_DOOR;
          timer_d = DOOR_LOAD;
          clr_d   = here_all;
          if (floor_q == FLOOR_2 && !ahead_cur) dir_d = ~dir_q;
        end else if (state_q == S_DOOR && svc_here != '0) begin
          timer_d = DOOR_LOAD;
          clr_d   = svc_here;
        end else if (state_q == S_DOOR && timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (ahead_cur || behind_cur) begin
          dir_d   = ahead_cur ? dir_q : ~dir_q;
          state_d = (dir_d == DIR_UP) ? S_MOVE_UP : S_MOVE_DOWN;
          timer_d = TRAVEL_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if ((mv_up && floor_q == FLOOR_3) || (!mv_up && floor_q == FLOOR_1)) begin
          state_d = S_IDLE;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          floor_d = nfloor;
          if (svc_new != '0) begin
            state_d = S_DOOR;
            timer_d = DOOR_LOAD;
            clr_d   = svc_new;
            if (nfloor == FLOOR_2 && !nahead) dir_d = ~dir_q;
          end else if (nahead) begin
            timer_d = TRAVEL_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    door_d = (state_d == S_DOOR);
    case (floor_d)
      FLOOR_2: indi_d = 3'b010;
      FLOOR_3: indi_d = 3'b100;
      default: indi_d = 3'b001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      floor_q <= FLOOR_1;
      dir_q   <= DIR_UP;
      timer_q <= '0;
      indi_q  <= 3'b001;
      door_q  <= 1'b0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      indi_q  <= indi_d;
      door_q  <= door_d;
      clr_q   <= clr_d;
    end
  end

  assign floor_1_indi        = indi_q[0];
  assign floor_2_indi        = indi_q[1];
  assign floor_3_indi        = indi_q[2];
  assign door_open           = door_q;
  assign floor1up_clear      = clr_q[R_F1UP];
  assign floor2down_clear    = clr_q[R_F2DN];
  assign floor2up_clear      = clr_q[R_F2UP];
  assign floor3down_clear    = clr_q[R_F3DN];
  assign floor1_button_clear = clr_q[R_B1];
  assign floor2_button_clear = clr_q[R_B2];
  assign floor3_button_clear = clr_q[R_B3];

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler; request latches are modelled in the bench
// and released by the scheduler's clear pulses.
module tb_elevator_scheduler;

  localparam int unsigned TRAVEL = 8;
  localparam int unsigned DOOR   = 6;

  localparam logic [6:0] M_F1UP = 7'b0000001;
  localparam logic [6:0] M_F2DN = 7'b0000010;
  localparam logic [6:0] M_F2UP = 7'b0000100;
  localparam logic [6:0] M_B1   = 7'b0010000;
  localparam logic [6:0] M_B2   = 7'b0100000;
  localparam logic [6:0] M_B3   = 7'b1000000;

  // {floor3, floor2, floor1, door}
  localparam logic [3:0] P_F1      = 4'b0010;
  localparam logic [3:0] P_F1_DOOR = 4'b0011;
  localparam logic [3:0] P_F2      = 4'b0100;
  localparam logic [3:0] P_F2_DOOR = 4'b0101;
  localparam logic [3:0] P_F3      = 4'b1000;
  localparam logic [3:0] P_F3_DOOR = 4'b1001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] set_req = '0;
  logic [6:0] lat = '0;
  logic [6:0] clr;
  logic [3:0] pos;

  logic floor_1_indi, floor_2_indi, floor_3_indi, door_open;
  logic floor1up_clear, floor2down_clear, floor2up_clear, floor3down_clear;
  logic floor1_button_clear, floor2_button_clear, floor3_button_clear;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .floor1up            (lat[0]),
    .floor2down          (lat[1]),
    .floor2up            (lat[2]),
    .floor3down          (lat[3]),
    .floor1button        (lat[4]),
    .floor2button        (lat[5]),
    .floor3button        (lat[6]),
    .floor_1_indi        (floor_1_indi),
    .floor_2_indi        (floor_2_indi),
    .floor_3_indi        (floor_3_indi),
    .door_open           (door_open),
    .floor1up_clear      (floor1up_clear),
    .floor2down_clear    (floor2down_clear),
    .floor2up_clear      (floor2up_clear),
    .floor3down_clear    (floor3down_clear),
    .floor1_button_clear (floor1_button_clear),
    .floor2_button_clear (floor2_button_clear),
    .floor3_button_clear (floor3_button_clear)
  );

  assign clr = {floor3_button_clear, floor2_button_clear, floor1_button_clear,
                floor3down_clear, floor2up_clear, floor2down_clear, floor1up_clear};
  assign pos = {floor_3_indi, floor_2_indi, floor_1_indi, door_open};

  // Set/clear request latches; they survive reset
  always @(posedge clk) lat <= (lat | set_req) & ~clr;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: latch goes high on the next posedge, scheduler sees it one edge later
  task automatic raise(input logic [6:0] m);
    set_req = m;
    @(negedge clk);
    set_req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({pos, clr} !== {P_F1, 7'b0}) begin
      tests_failed++;
      $display("FAIL reset_values got=%b want=%b", {pos, clr}, {P_F1, 7'b0});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      tests_run++;
      if ({pos, clr} !== {P_F1, 7'b0}) begin
        tests_failed++;
        $display("FAIL reset_idle cycle=%0d got=%b want=%b", i, {pos, clr}, {P_F1, 7'b0});
      end
    end
  endtask

  task automatic test_local_service();
    int door_cnt;
    int clr_cnt;
    raise(M_F1UP);
    tick(1);
    tests_run++;
    if ({pos, clr} !== {P_F1_DOOR, M_F1UP}) begin
      tests_failed++;
      $display("FAIL local_open got=%b want=%b", {pos, clr}, {P_F1_DOOR, M_F1UP});
    end
    door_cnt = 1;
    clr_cnt  = 1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (clr != 7'b0) clr_cnt++;
      if (!door_open) break;
      door_cnt++;
    end
    tests_run++;
    if (door_cnt != 6) begin
      tests_failed++;
      $display("FAIL local_door_time got=%0d want=6", door_cnt);
    end
    tests_run++;
    if (clr_cnt != 1) begin
      tests_failed++;
      $display("FAIL local_clear_width got=%0d want=1", clr_cnt);
    end
    tick(3);
    tests_run++;
    if ({pos, clr} !== {P_F1, 7'b0}) begin
      tests_failed++;
      $display("FAIL local_back_idle got=%b want=%b", {pos, clr}, {P_F1, 7'b0});
    end
  endtask

  task automatic test_same_floor();
    raise(M_F1UP | M_B1);
    tick(1);
    tests_run++;
    if ({pos, clr} !== {P_F1_DOOR, M_F1UP | M_B1}) begin
      tests_failed++;
      $display("FAIL same_floor_clear got=%b want=%b", {pos, clr}, {P_F1_DOOR, M_F1UP | M_B1});
    end
    tick(6);
    tests_run++;
    if ({pos, clr} !== {P_F1, 7'b0}) begin
      tests_failed++;
      $display("FAIL same_floor_close got=%b want=%b", {pos, clr}, {P_F1, 7'b0});
    end
  endtask

  task automatic test_express();
    raise(M_B3);
    tick(8);
    tests_run++;
    if ({pos, clr} !== {P_F1, 7'b0}) begin
      tests_failed++;
      $display("FAIL express_pre_f2 got=%b want=%b", {pos, clr}, {P_F1, 7'b0});
    end
    tick(1);
    tests_run++;
    if ({pos, clr} !== {P_F2, 7'b0}) begin
      tests_failed++;
      $display("FAIL express_pass_f2 got=%b want=%b", {pos, clr}, {P_F2, 7'b0});
    end
    tick(7);
    tests_run++;
    if ({pos, clr} !== {P_F2, 7'b0}) begin
      tests_failed++;
      $display("FAIL express_pre_f3 got=%b want=%b", {pos, clr}, {P_F2, 7'b0});
    end
    tick(1);
    tests_run++;
    if ({pos, clr} !== {P_F3_DOOR, M_B3}) begin
      tests_failed++;
      $display("FAIL express_arrive_f3 got=%b want=%b", {pos, clr}, {P_F3_DOOR, M_B3});
    end
    tick(6);
    tests_run++;
    if ({pos, clr} !== {P_F3, 7'b0}) begin
      tests_failed++;
      $display("FAIL express_close got=%b want=%b", {pos, clr}, {P_F3, 7'b0});
    end
  endtask

  task automatic test_sweep_order();
    do_reset();
    raise(M_B3);
    tick(3);
    raise(M_F2DN);
    tick(5);
    tests_run++;
    if ({pos, clr} !== {P_F2, 7'b0}) begin
      tests_failed++;
      $display("FAIL sweep_skip_f2 got=%b want=%b", {pos, clr}, {P_F2, 7'b0});
    end
    tick(8);
    tests_run++;
    if ({pos, clr} !== {P_F3_DOOR, M_B3}) begin
      tests_failed++;
      $display("FAIL sweep_serve_f3 got=%b want=%b", {pos, clr}, {P_F3_DOOR, M_B3});
    end
    tick(6);
    tests_run++;
    if ({pos, clr} !== {P_F3, 7'b0}) begin
      tests_failed++;
      $display("FAIL sweep_leave_f3 got=%b want=%b", {pos, clr}, {P_F3, 7'b0});
    end
    tick(8);
    tests_run++;
    if ({pos, clr} !== {P_F2_DOOR, M_F2DN}) begin
      tests_failed++;
      $display("FAIL sweep_serve_f2 got=%b want=%b", {pos, clr}, {P_F2_DOOR, M_F2DN});
    end
    tick(10);
    tests_run++;
    if ({pos, clr} !== {P_F2, 7'b0}) begin
      tests_failed++;
      $display("FAIL sweep_idle_f2 got=%b want=%b", {pos, clr}, {P_F2, 7'b0});
    end
  endtask

  task automatic test_door_extension();
    int door_cnt;
    do_reset();
    raise(M_F2UP | M_B3);
    tick(9);
    tests_run++;
    if ({pos, clr} !== {P_F2_DOOR, M_F2UP}) begin
      tests_failed++;
      $display("FAIL ext_open_f2 got=%b want=%b", {pos, clr}, {P_F2_DOOR, M_F2UP});
    end
    door_cnt = 1;
    tick(1);
    if (door_open) door_cnt++;
    tick(1);
    if (door_open) door_cnt++;
    raise(M_B2);
    if (door_open) door_cnt++;
    tests_run++;
    if (clr !== 7'b0) begin
      tests_failed++;
      $display("FAIL ext_no_early_clear got=%b want=%b", clr, 7'b0);
    end
    tick(1);
    if (door_open) door_cnt++;
    tests_run++;
    if ({pos, clr} !== {P_F2_DOOR, M_B2}) begin
      tests_failed++;
      $display("FAIL ext_reload_clear got=%b want=%b", {pos, clr}, {P_F2_DOOR, M_B2});
    end
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (!door_open) break;
      door_cnt++;
    end
    tests_run++;
    if (door_cnt != 10) begin
      tests_failed++;
      $display("FAIL ext_door_time got=%0d want=10", door_cnt);
    end
    tick(8);
    tests_run++;
    if ({pos, clr} !== {P_F3_DOOR, M_B3}) begin
      tests_failed++;
      $display("FAIL ext_then_f3 got=%b want=%b", {pos, clr}, {P_F3_DOOR, M_B3});
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    raise(M_B3);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tests_run++;
    if ({pos, clr} !== {P_F1, 7'b0}) begin
      tests_failed++;
      $display("FAIL midreset_values got=%b want=%b", {pos, clr}, {P_F1, 7'b0});
    end
    tick(8);
    tests_run++;
    if ({pos, clr} !== {P_F1, 7'b0}) begin
      tests_failed++;
      $display("FAIL midreset_restart got=%b want=%b", {pos, clr}, {P_F1, 7'b0});
    end
    tick(1);
    tests_run++;
    if ({pos, clr} !== {P_F2, 7'b0}) begin
      tests_failed++;
      $display("FAIL midreset_f2 got=%b want=%b", {pos, clr}, {P_F2, 7'b0});
    end
    tick(8);
    tests_run++;
    if ({pos, clr} !== {P_F3_DOOR, M_B3}) begin
      tests_failed++;
      $display("FAIL midreset_serve_f3 got=%b want=%b", {pos, clr}, {P_F3_DOOR, M_B3});
    end
  endtask

  initial begin
    test_reset();
    test_local_service();
    test_same_floor();
    test_express();
    test_sweep_order();
    test_door_extension();
    test_reset_mid_move();
    tick(8);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request-serving car controller for the three-floor elevator. It consumes the seven latched request levels produced by the button latches (hall calls and car buttons). It decides car motion and door timing using a directional sweep policy. It returns a one-cycle clear pulse to each latch it has served. It drives the floor indicators and the door output seen at the top level.

## Interface
- TRAVEL_CYCLES, 8, cycles to move one floor (≥2)
- DOOR_CYCLES, 6, cycles the door stays open per service (≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- floor1up, floor2down, floor2up, floor3down  in  1 each  latched hall-call levels
- floor1button, floor2button, floor3button  in  1 each  latched car-button levels
- floor_1_indi, floor_2_indi, floor_3_indi  out  1 each  one-hot current floor
- door_open  out  1  door open
- floor1up_clear, floor2down_clear, floor2up_clear, floor3down_clear  out  1 each  one-cycle clear pulse
- floor1_button_clear, floor2_button_clear, floor3_button_clear  out  1 each  one-cycle clear pulse

## Operation
- State: IDLE, DOOR, MOVE_UP, MOVE_DOWN. cur_floor is in 1..3. dir is UP or DOWN. Timer width is ceil(log2(max(TRAVEL_CYCLES,DOOR_CYCLES)+1)).
- Reset values:
  - state IDLE, cur_floor 1, dir UP, timer 0.
  - floor_1_indi 1, the other indicators 0.
  - door_open 0, all clears 0.
- Effective request = input AND NOT (its clear asserted this cycle). This masks the one-cycle latch release delay.
- "Ahead" means an effective request of any kind at a floor strictly beyond cur_floor in dir. "Behind" is the same in the opposite direction.
- Serviceable at floor f while travelling in dir:
  - the car button for f;
  - the hall call at f matching dir;
  - at floor 2 only, also the opposite hall call if nothing lies ahead;
  - at floors 1 and 3, the single hall call there.
- IDLE, evaluated in priority order:
  1. Any effective request at cur_floor: go to DOOR and clear all requests at cur_floor.
  2. Else something ahead: go to MOVE in dir.
  3. Else something behind: flip dir, then go to MOVE.
  4. Else stay in IDLE.
- DOOR:
  - door_open=1 and timer loads DOOR_CYCLES-1 on entry.
  - A newly serviceable request at cur_floor during DOOR is cleared the next cycle, and the timer reloads.
  - When the timer reaches 0, apply the IDLE priority rules 2–4, otherwise go to IDLE. Rule 1 cannot occur.
- MOVE_UP/MOVE_DOWN:
  - Timer loads TRAVEL_CYCLES-1 on entry and counts down.
  - At 0, cur_floor steps ±1 and the indicators update in the same edge.
  - If the new floor is serviceable, go to DOOR and issue the clears.
  - Else, if something is ahead, reload and keep moving. This applies only when passing floor 2.
  - Else go to IDLE. This is a defensive case, since only this block clears requests.
- Clear set on a DOOR entry at floor 2:
  - floor2_button, plus the hall call matching dir.
  - If nothing is ahead, dir flips and the opposite hall call is cleared as well.
- The car never moves while door_open=1. The car never moves beyond floors 1 or 3.

## Timing
- All outputs are registered. Clears are asserted for exactly one cycle, coincident with the first DOOR cycle, or with the reload cycle in DOOR.
- Request at the current floor while IDLE: door_open rises 1 cycle after the request is first sampled high.
- Door time: door_open stays high for exactly DOOR_CYCLES cycles per service, or longer if reloaded.
- Travel time: the floor indicator changes TRAVEL_CYCLES cycles after the MOVE entry edge. door_open rises on that same edge when the car stops.
- Simultaneous requests: all requests at the same floor are served together. Requests at different floors are served in sweep order, never by request age.
- Reset mid-operation: rst overrides everything in the cycle it is sampled, and all outputs take their reset values on that edge. Latched requests remain pending and are re-served after reset.

## Test plan
- Reset: after rst is high for 1 cycle, expect floor_1_indi=1, door_open=0, and all clears 0. No activity for 20 idle cycles.
- Local service: IDLE at floor 1, pulse floor1up latched.
  - Next cycle: door_open=1 and floor1up_clear for exactly 1 cycle.
  - door_open stays high for 6 cycles, then the block returns to IDLE.
- Express run: floor3button at floor 1.
  - Expect the car to pass floor 2 at +8 without opening.
  - At floor 3 (+16 from MOVE entry): door_open=1 and floor3_button_clear pulses.
- Sweep order: car moving up from floor 1 with floor3button pending; assert floor2down mid-travel.
  - No stop at floor 2 on the way up.
  - After floor 3 is served, the car returns down, stops at floor 2, and floor2down_clear pulses.
- Door extension: during DOOR at floor 2 (dir UP), assert floor2button at door cycle 3. Expect floor2_button_clear the next cycle and a total door time of 3+1+6 cycles.
- Reset mid-move: assert rst while MOVE_UP timer=4 with floor3button held. Expect floor 1 and IDLE after reset, then the car re-departs and serves floor 3.
